// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the control unit (master) and the memory
// responder (slave).
//   addr     : word address taken from MAR
//   wr_data  : write data taken from MDR
//   read     : read request (only looked at while the responder is idle)
//   write    : write request (only looked at while the responder is idle)
//   rd_data  : registered read data returned to MDR
//   done     : one-cycle completion strobe
//   busy     : responder is working on a transaction
//   err      : one-cycle strobe for a request with both read and write high
// ---------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  done;
  logic                  busy;
  logic                  err;

  modport master (
    output addr, wr_data, read, write,
    input  rd_data, done, busy, err
  );

  modport slave (
    input  addr, wr_data, read, write,
    output rd_data, done, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder: a 2**ADDR_WIDTH x DATA_WIDTH word store served
// through a small IDLE -> WAIT -> ACCESS -> DONE sequencer with a
// programmable number of wait states (0..15).
//
// Ports:
//   clock : system clock, rising edge
//   clear : asynchronous active-low reset (array contents are kept)
//   bus   : mem_responder_if slave modport (addr, wr_data, read, write in;
//           rd_data, done, busy, err out)
//
// Transaction timing: a request accepted at edge E produces done in the
// cycle that starts WAIT_STATES+1 edges after E; busy covers
// WAIT_STATES+2 cycles. Requests seen while busy are dropped silently.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic            clock,
  input  logic            clear,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_r;
  logic [3:0]            wait_cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  is_write_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  done_r;
  logic                  busy_r;
  logic                  err_r;

  // Storage array; deliberately has no reset so contents survive clear.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  req_one_s;
  logic                  req_both_s;
  logic                  mem_we_s;

  // Request decode: exactly one of read/write is a legal request.
  always_comb begin
    req_one_s  = 1'b0;
    req_both_s = 1'b0;
    if (bus.read && bus.write) begin
      req_both_s = 1'b1;
    end else if (bus.read || bus.write) begin
      req_one_s = 1'b1;
    end else begin
      req_one_s  = 1'b0;
      req_both_s = 1'b0;
    end
  end

  // Array write enable: only during ACCESS of a latched write. A reset
  // asserted before the ACCESS edge drops state to IDLE, so the write is lost.
  always_comb begin
    mem_we_s = 1'b0;
    if (state_r == ST_ACCESS && is_write_r) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Sequencer with registered done/busy/err/rd_data and request latches.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      addr_r     <= '0;
      wdata_r    <= '0;
      is_write_r <= 1'b0;
      rd_data_r  <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (req_one_s) begin
            addr_r     <= bus.addr;
            wdata_r    <= bus.wr_data;
            is_write_r <= bus.write;
            busy_r     <= 1'b1;
            err_r      <= 1'b0;
            if (WAIT_STATES > 0) begin
              state_r    <= ST_WAIT;
              wait_cnt_r <= WAIT_LOAD;
            end else begin
              state_r    <= ST_ACCESS;
              wait_cnt_r <= 4'd0;
            end
          end else if (req_both_s) begin
            // Illegal request: flag it and stay idle without touching anything.
            err_r  <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            err_r  <= 1'b0;
            busy_r <= 1'b0;
          end
        end

        ST_WAIT: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          busy_r <= 1'b1;
          // Counter is loaded with WAIT_STATES, so leaving on 1 spends
          // exactly WAIT_STATES cycles here.
          if (wait_cnt_r == 4'd1) begin
            state_r    <= ST_ACCESS;
            wait_cnt_r <= 4'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end

        ST_ACCESS: begin
          err_r   <= 1'b0;
          busy_r  <= 1'b1;
          done_r  <= 1'b1;
          state_r <= ST_DONE;
          if (!is_write_r) begin
            rd_data_r <= mem_r[addr_r];
          end else begin
            rd_data_r <= rd_data_r;
          end
        end

        ST_DONE: begin
          // No sampling here; the next request is accepted one edge later.
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 4'd0;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          err_r      <= 1'b0;
        end
      endcase
    end
  end

  // Array write port.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

  assign bus.rd_data = rd_data_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. Two instances are exercised: one
// with WAIT_STATES=0 (selector 0) and one with WAIT_STATES=2 (selector 2).
// A directed vector table plus hand sequences cover the corner cases; a
// randomized phase is then checked against a transaction-level model (a
// word array per instance and the last value returned by a read).
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic clock;
  logic clear;

  int n_cmp;
  int n_bad;

  mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus0 ();
  mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus2 ();

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .clock (clock),
    .clear (clear),
    .bus   (bus0)
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut2 (
    .clock (clock),
    .clear (clear),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: per-instance memory image and last read result.
  logic [31:0] mdl [2][512];
  logic [31:0] rdm [2];
  logic [8:0]  wq0 [$];
  logic [8:0]  wq2 [$];

  typedef struct {
    int          sel;
    int          op;      // 0 read, 1 write, 2 both (illegal)
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    if (s == 0) begin
      bus0.read = rd; bus0.write = wr; bus0.addr = a; bus0.wr_data = d;
    end else begin
      bus2.read = rd; bus2.write = wr; bus2.addr = a; bus2.wr_data = d;
    end
  endtask

  function automatic logic [31:0] s_rd(input int s);
    return (s == 0) ? bus0.rd_data : bus2.rd_data;
  endfunction
  function automatic logic s_done(input int s);
    return (s == 0) ? bus0.done : bus2.done;
  endfunction
  function automatic logic s_busy(input int s);
    return (s == 0) ? bus0.busy : bus2.busy;
  endfunction
  function automatic logic s_err(input int s);
    return (s == 0) ? bus0.err : bus2.err;
  endfunction

  // One transaction: request for one cycle, then follow it to completion.
  // Optionally injects a write on the bus while the responder is busy.
  task automatic txn(input int s, input int op, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd,
                     input bit inj, input logic [8:0] ia, input logic [31:0] id);
    int n;
    bit seen;
    int ws;
    int i;
    ws = (s == 0) ? 0 : 2;
    i  = (s == 0) ? 0 : 1;
    @(negedge clock);
    drive(s, logic'(op != 1), logic'(op != 0), a, d);
    @(posedge clock);
    @(negedge clock);
    drive(s, 1'b0, 1'b0, 9'd0, 32'd0);
    if (op == 2) begin
      chk("err_strobe", 32'(s_err(s)), 32'd1);
      chk("err_busy", 32'(s_busy(s)), 32'd0);
      chk("err_done", 32'(s_done(s)), 32'd0);
      @(negedge clock);
      chk("err_one_cycle", 32'(s_err(s)), 32'd0);
      chk("err_rd_hold", s_rd(s), exp_rd);
    end else begin
      chk("busy_start", 32'(s_busy(s)), 32'd1);
      chk("rd_hold_start", s_rd(s), rdm[i]);
      if (inj) drive(s, 1'b0, 1'b1, ia, id);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        if (s_done(s)) begin
          seen = 1'b1;
        end else begin
          @(negedge clock);
          n++;
          if (n == 1) drive(s, 1'b0, 1'b0, 9'd0, 32'd0);
        end
      end
      drive(s, 1'b0, 1'b0, 9'd0, 32'd0);
      chk("done_seen", 32'(seen), 32'd1);
      chk("done_latency", 32'(n), 32'(ws + 1));
      chk("done_busy", 32'(s_busy(s)), 32'd1);
      chk("done_no_err", 32'(s_err(s)), 32'd0);
      chk("rd_data", s_rd(s), exp_rd);
      @(negedge clock);
      chk("idle_after", {30'd0, s_busy(s), s_done(s)}, 32'd0);
      if (op == 1) begin
        mdl[i][a] = d;
        if (i == 0) wq0.push_back(a); else wq2.push_back(a);
      end
      rdm[i] = exp_rd;
    end
  endtask

  initial begin
    int s;
    int i;
    int op;
    int r;
    logic [8:0] a;
    logic [31:0] d;
    logic [31:0] e;
    bit inj;

    n_cmp = 0;
    n_bad = 0;
    rdm[0] = 32'd0;
    rdm[1] = 32'd0;

    // Directed vectors: {sel, op, addr, data, expected rd_data at done}.
    tbl[0]  = '{2, 1, 9'h0A5, 32'hDEADBEEF, 32'h00000000};
    tbl[1]  = '{2, 0, 9'h0A5, 32'h00000000, 32'hDEADBEEF};
    tbl[2]  = '{0, 1, 9'h1FF, 32'h12345678, 32'h00000000};
    tbl[3]  = '{0, 0, 9'h1FF, 32'h00000000, 32'h12345678};
    tbl[4]  = '{2, 1, 9'h003, 32'h00000333, 32'hDEADBEEF};
    tbl[5]  = '{2, 1, 9'h004, 32'h00000444, 32'hDEADBEEF};
    tbl[6]  = '{2, 2, 9'h004, 32'hFFFFFFFF, 32'hDEADBEEF};
    tbl[7]  = '{2, 0, 9'h004, 32'h00000000, 32'h00000444};
    tbl[8]  = '{2, 1, 9'h010, 32'h0BADC0DE, 32'h00000444};
    tbl[9]  = '{0, 1, 9'h000, 32'hA5A5A5A5, 32'h12345678};
    tbl[10] = '{0, 0, 9'h000, 32'h00000000, 32'hA5A5A5A5};

    drive(0, 1'b0, 1'b0, 9'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 9'd0, 32'd0);
    clear = 1'b0;
    #1;
    chk("reset_rd0", s_rd(0), 32'd0);
    chk("reset_rd2", s_rd(2), 32'd0);
    chk("reset_flags0", {29'd0, s_done(0), s_busy(0), s_err(0)}, 32'd0);
    chk("reset_flags2", {29'd0, s_done(2), s_busy(2), s_err(2)}, 32'd0);
    repeat (3) @(negedge clock);
    clear = 1'b1;

    // Idle after reset: nothing may move.
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("idle_flags", {26'd0, s_done(0), s_busy(0), s_err(0),
                         s_done(2), s_busy(2), s_err(2)}, 32'd0);
    end

    for (int k = 0; k < 11; k++) begin
      txn(tbl[k].sel, tbl[k].op, tbl[k].addr, tbl[k].data, tbl[k].exp_rd,
          1'b0, 9'd0, 32'd0);
    end

    // Request raised while busy is dropped: 0x004 keeps 0x444.
    txn(2, 0, 9'h003, 32'd0, 32'h00000333, 1'b1, 9'h004, 32'h00000055);
    txn(2, 0, 9'h004, 32'd0, 32'h00000444, 1'b0, 9'd0, 32'd0);

    // Reset during WAIT of a write: no done, no commit, outputs clear at once.
    @(negedge clock);
    drive(2, 1'b0, 1'b1, 9'h010, 32'hCAFEF00D);
    @(posedge clock);
    @(negedge clock);
    drive(2, 1'b0, 1'b0, 9'd0, 32'd0);
    @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    chk("midrst_busy", 32'(s_busy(2)), 32'd0);
    chk("midrst_done", 32'(s_done(2)), 32'd0);
    chk("midrst_rd", s_rd(2), 32'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    rdm[0] = 32'd0;
    rdm[1] = 32'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("midrst_no_done", {30'd0, s_done(2), s_busy(2)}, 32'd0);
    end
    txn(2, 0, 9'h010, 32'd0, 32'h0BADC0DE, 1'b0, 9'd0, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 150; k++) begin
      s = ($urandom_range(1, 0) == 1) ? 2 : 0;
      i = (s == 0) ? 0 : 1;
      r = $urandom_range(9, 0);
      if (r == 0) op = 2;
      else if (r < 5) op = 1;
      else if ((i == 0 && wq0.size() == 0) || (i == 1 && wq2.size() == 0)) op = 1;
      else op = 0;
      if (op == 0) begin
        if (i == 0) a = wq0[$urandom_range(wq0.size() - 1, 0)];
        else        a = wq2[$urandom_range(wq2.size() - 1, 0)];
      end else begin
        r = $urandom_range(7, 0);
        if (r == 0)      a = 9'h1FF;
        else if (r == 1) a = 9'h000;
        else             a = 9'($urandom);
      end
      d = $urandom;
      e = (op == 0) ? mdl[i][a] : rdm[i];
      inj = (op != 2) && ($urandom_range(3, 0) == 0);
      txn(s, op, a, d, e, inj, 9'($urandom), 32'($urandom));
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's 9-bit word address.
- Accepts read/write requests from the control unit, addressed by the low 9 bits of MAR.
- Provides a 512 x 32 word store with programmable wait states and a single-cycle completion strobe (done) that the control unit waits on before loading MDR or issuing the next step.

Parameters:
ADDR_WIDTH, 9, word address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width
WAIT_STATES, 2, extra cycles between request acceptance and the array access; legal range 0..15

Ports:
clock  input  1  system clock, rising-edge
clear  input  1  asynchronous active-low reset
addr  input  ADDR_WIDTH  word address from MAR (MAR[8:0])
wr_data  input  DATA_WIDTH  write data from MDR
read  input  1  read request, sampled only in IDLE
write  input  1  write request, sampled only in IDLE
rd_data  output  DATA_WIDTH  registered read data to MDR
done  output  1  one-cycle completion strobe
busy  output  1  high whenever state is not IDLE
err  output  1  one-cycle strobe for an illegal request (read and write both high)

Behaviour:
- Reset: clear low asynchronously forces the following, regardless of clock.
  - state = IDLE, wait counter = 0.
  - rd_data = 0, done = 0, busy = 0, err = 0.
  - Latched address/data registers = 0.
  - Array contents are NOT cleared.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Exactly one of read/write high at a rising edge = request accepted.
  - addr, wr_data and the operation type are latched at that edge.
  - Next state is WAIT if WAIT_STATES > 0; counter is loaded with WAIT_STATES.
  - Next state is ACCESS if WAIT_STATES = 0.
- IDLE, both read and write high: request rejected, err = 1 for exactly one cycle, state stays IDLE, no array or rd_data change.
- IDLE, neither request high: stay IDLE.
- WAIT:
  - Counter == 1: go to ACCESS.
  - Otherwise: decrement the counter.
  - Exactly WAIT_STATES cycles are spent in WAIT.
- ACCESS (one cycle), at the exiting edge:
  - Write: array[latched addr] <= latched wr_data.
  - Read: rd_data <= array[latched addr].
  - Next state is DONE.
- DONE (one cycle): done = 1, then return to IDLE.
  - No new request is sampled in DONE; the earliest next acceptance is the edge after DONE.
- Latency: done is high in the cycle that starts WAIT_STATES+1 edges after the accepting edge.
  - Total occupancy = WAIT_STATES+2 cycles per transaction.
- rd_data:
  - Changes only at a read's ACCESS->DONE edge or on reset.
  - Holds its value through subsequent writes and idle cycles.
- Request hold: read/write/addr/wr_data may change or drop after the accepting edge without effect. Requests asserted while busy = 1 are ignored, not queued, and do not raise err.
- Read-after-write to the same address in back-to-back transactions returns the newly written value.
- Address range: all 2**ADDR_WIDTH addresses are valid, with no wrap or out-of-range case. Address 511 is accessed normally.
- Reset mid-transaction: a write aborted before its ACCESS edge is not committed. done never asserts for an aborted transaction.
- done, busy and err are registered, with no combinational path from inputs to them.
- done and err are never high in the same cycle.

Test Plan:
1. Reset then idle:
   - clear low mid-cycle -> all outputs 0 immediately.
   - After release with no requests for 10 cycles -> done/busy/err stay 0.
2. Write then read, WAIT_STATES=2:
   - write addr=0x0A5, wr_data=0xDEADBEEF -> busy high 4 cycles, done pulses on the 3rd edge after acceptance, rd_data unchanged (0).
   - Then read addr=0x0A5 -> done after 3 edges, rd_data=0xDEADBEEF.
3. WAIT_STATES=0 back-to-back:
   - write 0x1FF <- 0x12345678 -> done on the next edge.
   - Then read 0x1FF, accepted on the edge after DONE -> rd_data=0x12345678, 2-cycle occupancy each.
4. Illegal request:
   - read=write=1 in IDLE -> err=1 for one cycle, busy stays 0, no done.
   - A later read of the target address returns its prior content.
5. Ignored request:
   - Start a read of 0x003; pulse write to 0x004 with 0x55 while busy.
   - Reading 0x004 afterwards returns its prior value; only one done is seen for the first read.
6. Reset mid-write, WAIT_STATES=2:
   - Write 0x010 <- 0xCAFEF00D; assert clear during WAIT.
   - done never pulses, and a subsequent read of 0x010 returns the old value.
